// File: rtl/nasti_order_pkg.sv
// Shared types and the address-to-port decode for the NASTI order guard.
// The decode must stay bit-identical to the downstream 1:8 demux.
package nasti_order_pkg;
    localparam int NPORTS     = 8;
    localparam int MAX_ADDR_W = 64;
    localparam int MAX_CNT_W  = 16;

    typedef logic [2:0] port_t;

    // cnt is sized for the widest supported CNT_WIDTH; bits above CNT_WIDTH never toggle
    typedef struct packed {
        port_t                port;
        logic [MAX_CNT_W-1:0] cnt;
    } order_entry_t;

    function automatic port_t port_decode(
        input logic [MAX_ADDR_W-1:0]             addr,
        input logic [NPORTS-1:0][MAX_ADDR_W-1:0] base,
        input logic [NPORTS-1:0][MAX_ADDR_W-1:0] mask
    );
        port_t p = '0;
        // scan downward so the lowest matching port wins
        for (int i = NPORTS - 1; i >= 0; i--)
            if (mask[i] != '0 && (addr & ~mask[i]) == base[i])
                p = port_t'(i);
        return p;
    endfunction
endpackage

// File: rtl/nasti_channel.sv
// NASTI channel bundle (AW/W/B/AR/R) with master and slave views.
interface nasti_channel #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [USER_WIDTH-1:0]   aw_user;
    logic                    aw_valid, aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid, w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid, b_ready;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [USER_WIDTH-1:0]   ar_user;
    logic                    ar_valid, ar_ready;

    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid, r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_user, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
        input  b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_user, ar_valid, input ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_user, aw_valid, output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
        output b_id, b_resp, b_user, b_valid, input b_ready,
        input  ar_id, ar_addr, ar_len, ar_user, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
    );
endinterface

// File: rtl/nasti_id_tracker.sv
// Per-ID outstanding table for one direction: {port, cnt} per ID, stall on
// port conflict or saturation, sticky error on a retire with nothing outstanding.
module nasti_id_tracker
    import nasti_order_pkg::*;
#(
    parameter int ID_WIDTH  = 1,
    parameter int CNT_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ID_WIDTH-1:0] req_id,
    input  port_t               req_port,
    input  logic                inc,
    input  logic                dec,
    input  logic [ID_WIDTH-1:0] dec_id,
    output logic                stall,
    output logic                err
);
    localparam int NIDS = 2 ** ID_WIDTH;
    localparam logic [MAX_CNT_W-1:0] CNT_MAX = MAX_CNT_W'((2 ** CNT_WIDTH) - 1);
    localparam logic [MAX_CNT_W-1:0] ONE     = MAX_CNT_W'(1);

    order_entry_t [NIDS-1:0] tbl_q, tbl_d;
    logic same_id, dec_ok;

    assign stall   = tbl_q[req_id].cnt != '0 &&
                     (tbl_q[req_id].port != req_port || tbl_q[req_id].cnt == CNT_MAX);
    assign same_id = inc && dec && dec_id == req_id;
    assign dec_ok  = dec && tbl_q[dec_id].cnt != '0;

    // a simultaneous request and retire on one ID cancel out in the count
    always_comb begin
        tbl_d = tbl_q;
        if (inc)
            tbl_d[req_id].port = req_port;
        if (inc && !(same_id && dec_ok))
            tbl_d[req_id].cnt = tbl_q[req_id].cnt + ONE;
        if (dec_ok && !same_id)
            tbl_d[dec_id].cnt = tbl_q[dec_id].cnt - ONE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tbl_q <= '0;
            err   <= 1'b0;
        end else begin
            tbl_q <= tbl_d;
            if (dec && !dec_ok)
                err <= 1'b1;
        end
    end
endmodule

// File: rtl/nasti_order_guard.sv
// Stalls AR/AW whose ID is still outstanding on another demux port so same-ID
// responses cannot be reordered. Optional stall counters: NASTI_ORDER_GUARD_STAT_EN.
module nasti_order_guard
    import nasti_order_pkg::*;
#(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int LITE_MODE  = 0,
    parameter int CNT_WIDTH  = 4,
    parameter logic [NPORTS-1:0][ADDR_WIDTH-1:0] BASE = '0,
    parameter logic [NPORTS-1:0][ADDR_WIDTH-1:0] MASK = '0
) (
    input  logic        clk,
    input  logic        rstn,
    nasti_channel.slave  s,
    nasti_channel.master m,
    output logic        rd_err,
    output logic        wr_err
`ifdef NASTI_ORDER_GUARD_STAT_EN
    ,
    output logic [31:0] ar_stall_cnt,
    output logic [31:0] aw_stall_cnt
`endif
);
    logic [NPORTS-1:0][MAX_ADDR_W-1:0] base_x, mask_x;
    port_t ar_port, aw_port;
    logic  ar_stall, aw_stall, ar_fire, aw_fire, r_ret, b_ret;

    for (genvar i = 0; i < NPORTS; i++) begin : g_map
        assign base_x[i] = MAX_ADDR_W'(BASE[i]);
        assign mask_x[i] = MAX_ADDR_W'(MASK[i]);
    end

    assign ar_port = port_decode(MAX_ADDR_W'(s.ar_addr), base_x, mask_x);
    assign aw_port = port_decode(MAX_ADDR_W'(s.aw_addr), base_x, mask_x);
    assign ar_fire = s.ar_valid && !ar_stall && m.ar_ready;
    assign aw_fire = s.aw_valid && !aw_stall && m.aw_ready;
    assign r_ret   = m.r_valid && s.r_ready && (m.r_last || LITE_MODE != 0);
    assign b_ret   = m.b_valid && s.b_ready;

    nasti_id_tracker #(.ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_rd (
        .clk(clk), .rstn(rstn), .req_id(s.ar_id), .req_port(ar_port), .inc(ar_fire),
        .dec(r_ret), .dec_id(m.r_id), .stall(ar_stall), .err(rd_err)
    );

    nasti_id_tracker #(.ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_wr (
        .clk(clk), .rstn(rstn), .req_id(s.aw_id), .req_port(aw_port), .inc(aw_fire),
        .dec(b_ret), .dec_id(m.b_id), .stall(aw_stall), .err(wr_err)
    );

    assign m.ar_id    = s.ar_id;
    assign m.ar_addr  = s.ar_addr;
    assign m.ar_len   = s.ar_len;
    assign m.ar_user  = USER_WIDTH'(s.ar_user);
    assign m.ar_valid = s.ar_valid && !ar_stall;
    assign s.ar_ready = m.ar_ready && !ar_stall;

    assign m.aw_id    = s.aw_id;
    assign m.aw_addr  = s.aw_addr;
    assign m.aw_len   = s.aw_len;
    assign m.aw_user  = USER_WIDTH'(s.aw_user);
    assign m.aw_valid = s.aw_valid && !aw_stall;
    assign s.aw_ready = m.aw_ready && !aw_stall;

    assign m.w_data   = DATA_WIDTH'(s.w_data);
    assign m.w_strb   = (DATA_WIDTH/8)'(s.w_strb);
    assign m.w_last   = s.w_last;
    assign m.w_user   = USER_WIDTH'(s.w_user);
    assign m.w_valid  = s.w_valid;
    assign s.w_ready  = m.w_ready;

    assign s.b_id     = m.b_id;
    assign s.b_resp   = m.b_resp;
    assign s.b_user   = USER_WIDTH'(m.b_user);
    assign s.b_valid  = m.b_valid;
    assign m.b_ready  = s.b_ready;

    assign s.r_id     = m.r_id;
    assign s.r_data   = DATA_WIDTH'(m.r_data);
    assign s.r_resp   = m.r_resp;
    assign s.r_last   = m.r_last;
    assign s.r_user   = USER_WIDTH'(m.r_user);
    assign s.r_valid  = m.r_valid;
    assign m.r_ready  = s.r_ready;

`ifdef NASTI_ORDER_GUARD_STAT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ar_stall_cnt <= '0;
            aw_stall_cnt <= '0;
        end else begin
            if (s.ar_valid && ar_stall && ar_stall_cnt != '1)
                ar_stall_cnt <= ar_stall_cnt + 32'd1;
            if (s.aw_valid && aw_stall && aw_stall_cnt != '1)
                aw_stall_cnt <= aw_stall_cnt + 32'd1;
        end
    end
`endif
endmodule
